// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared constants and types for the MEM pipeline stage.
//   - writeback bubble constants (NOPRegAddr, WriteDisable, ZeroWord)
//   - stall vector width and the mem_wb hold bit position
//   - memory op codes (mem_op_t), access size codes (mem_size_t)
//   - MEM stage FSM states (state_t)
//   - op classification helpers used by the stage and its load extender
package mem_access_pkg;

   localparam logic [4:0]  NOPRegAddr   = 5'b00000;
   localparam logic        WriteDisable = 1'b0;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;

   localparam int unsigned StallBusWidth = 7;
   localparam int unsigned StallMemWb    = 5;

   typedef enum logic [3:0] {
      MEM_NOP = 4'd0,
      MEM_LB  = 4'd1,
      MEM_LH  = 4'd2,
      MEM_LW  = 4'd3,
      MEM_LBU = 4'd4,
      MEM_LHU = 4'd5,
      MEM_SB  = 4'd6,
      MEM_SH  = 4'd7,
      MEM_SW  = 4'd8
   } mem_op_t;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b11
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic op_is_store(input mem_op_t op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

   function automatic logic op_is_load(input mem_op_t op);
      return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
             (op == MEM_LBU) || (op == MEM_LHU);
   endfunction

   function automatic logic [1:0] op_size(input mem_op_t op);
      logic [1:0] size;
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: size = SIZE_B;
         MEM_LH, MEM_LHU, MEM_SH: size = SIZE_H;
         MEM_LW, MEM_SW:          size = SIZE_W;
         default:                 size = SIZE_B;
      endcase
      return size;
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: request/done bus between the MEM stage and the memory
// controller.
//   mc_req   level request, held until mc_done
//   mc_we    1 = store
//   mc_addr  access address
//   mc_size  00 byte, 01 half, 11 word
//   mc_wdata store data, low-aligned
//   mc_done  one-cycle completion pulse from the controller
//   mc_rdata load data, low-aligned, valid with mc_done
// master = MEM stage, slave = memory controller.
interface mem_access_if;

   logic        mc_req;
   logic        mc_we;
   logic [31:0] mc_addr;
   logic [1:0]  mc_size;
   logic [31:0] mc_wdata;
   logic        mc_done;
   logic [31:0] mc_rdata;

   modport master (
      output mc_req, mc_we, mc_addr, mc_size, mc_wdata,
      input  mc_done, mc_rdata
   );

   modport slave (
      input  mc_req, mc_we, mc_addr, mc_size, mc_wdata,
      output mc_done, mc_rdata
   );

endinterface

// File: rtl/mem_access_load_ext.sv
// load_ext: combinational load result extender.
//   op  memory op (selects sign/zero extension and width)
//   raw low-aligned data returned by the memory controller
//   ext 32-bit value to write back
// LW and every non-narrow-load op pass raw through unchanged.
module load_ext
   import mem_access_pkg::*;
(
   input  mem_op_t     op,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   always_comb begin
      ext = raw;
      case (op)
         MEM_LB:  ext = {{24{raw[7]}}, raw[7:0]};
         MEM_LBU: ext = {24'h000000, raw[7:0]};
         MEM_LH:  ext = {{16{raw[15]}}, raw[15:0]};
         MEM_LHU: ext = {16'h0000, raw[15:0]};
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage of the 5-stage pipeline, between ex_mem and mem_wb.
//   clk, rst         clock, synchronous active-high reset
//   stall_sign       stall vector from ctrl; bit 5 = mem_wb held
//   ex_wd/wreg/wdata writeback triple from ex_mem
//   ex_memop         memory op (mem_op_t encoding)
//   ex_mem_addr      effective address
//   ex_mem_sdata     store data
//   mem_wd/wreg/wdata writeback triple to mem_wb
//   stallreq         holds the pipeline while an access is outstanding
//   mc               master side of the memory controller bus
// Non-memory ops pass straight through. A memory op is issued the cycle it
// is seen in IDLE, waits for mc_done, then presents its result in DONE for
// exactly one advancing cycle.
module mem_access
   import mem_access_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [StallBusWidth-1:0] stall_sign,
   input  logic [4:0]               ex_wd,
   input  logic                     ex_wreg,
   input  logic [31:0]              ex_wdata,
   input  logic [3:0]               ex_memop,
   input  logic [31:0]              ex_mem_addr,
   input  logic [31:0]              ex_mem_sdata,
   output logic [4:0]               mem_wd,
   output logic                     mem_wreg,
   output logic [31:0]              mem_wdata,
   output logic                     stallreq,
   mem_access_if.master             mc
);

   state_t      state;
   mem_op_t     op;
   logic [31:0] ld_q;
   logic [31:0] ld_ext;
   logic        unused_stall;

   assign op = mem_op_t'(ex_memop);

   // Only the mem_wb hold bit matters to this stage.
   assign unused_stall = ^{stall_sign[6], stall_sign[4:0]};

   load_ext u_load_ext (
      .op  (op),
      .raw (mc.mc_rdata),
      .ext (ld_ext)
   );

   // mc_done is only honoured in WAIT, so late or stray pulses after a
   // reset or during DONE cannot disturb ld_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ld_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (op != MEM_NOP) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (mc.mc_done) begin
                  ld_q  <= ld_ext;
                  state <= DONE;
               end
            end
            DONE: begin
               if (!stall_sign[StallMemWb]) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are decoded combinationally from state and the ex_* inputs so
   // that passthrough and issue both happen in the cycle the op arrives.
   // The mc_* fields are zeroed whenever no request is outstanding.
   always_comb begin
      mem_wd      = NOPRegAddr;
      mem_wreg    = WriteDisable;
      mem_wdata   = ZeroWord;
      stallreq    = 1'b0;
      mc.mc_req   = 1'b0;
      mc.mc_we    = 1'b0;
      mc.mc_addr  = '0;
      mc.mc_size  = '0;
      mc.mc_wdata = '0;
      case (state)
         IDLE: begin
            if (op == MEM_NOP) begin
               mem_wd    = ex_wd;
               mem_wreg  = ex_wreg;
               mem_wdata = ex_wdata;
            end else begin
               stallreq    = 1'b1;
               mc.mc_req   = 1'b1;
               mc.mc_we    = op_is_store(op);
               mc.mc_addr  = ex_mem_addr;
               mc.mc_size  = op_size(op);
               mc.mc_wdata = ex_mem_sdata;
            end
         end
         WAIT: begin
            stallreq    = 1'b1;
            mc.mc_req   = 1'b1;
            mc.mc_we    = op_is_store(op);
            mc.mc_addr  = ex_mem_addr;
            mc.mc_size  = op_size(op);
            mc.mc_wdata = ex_mem_sdata;
         end
         DONE: begin
            mem_wd    = ex_wd;
            mem_wreg  = ex_wreg;
            mem_wdata = op_is_load(op) ? ld_q : ex_wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed, table-driven bench for the MEM stage.
module tb_mem_access;
   import mem_access_pkg::*;

   logic                     clk;
   logic                     rst;
   logic [StallBusWidth-1:0] stall_sign;
   logic [4:0]               ex_wd;
   logic                     ex_wreg;
   logic [31:0]              ex_wdata;
   logic [3:0]               ex_memop;
   logic [31:0]              ex_mem_addr;
   logic [31:0]              ex_mem_sdata;
   logic [4:0]               mem_wd;
   logic                     mem_wreg;
   logic [31:0]              mem_wdata;
   logic                     stallreq;

   int checks = 0;
   int errors = 0;

   mem_access_if mc_bus();

   mem_access dut (
      .clk          (clk),
      .rst          (rst),
      .stall_sign   (stall_sign),
      .ex_wd        (ex_wd),
      .ex_wreg      (ex_wreg),
      .ex_wdata     (ex_wdata),
      .ex_memop     (ex_memop),
      .ex_mem_addr  (ex_mem_addr),
      .ex_mem_sdata (ex_mem_sdata),
      .mem_wd       (mem_wd),
      .mem_wreg     (mem_wreg),
      .mem_wdata    (mem_wdata),
      .stallreq     (stallreq),
      .mc           (mc_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   typedef struct packed {
      logic [3:0]  op;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [4:0]  e_wd;
      logic        e_wreg;
      logic [31:0] e_wdata;
      logic        e_stall;
      logic        e_req;
      logic        e_we;
      logic [1:0]  e_size;
      logic [31:0] e_addr;
      logic [31:0] e_mcw;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_nop();
      ex_memop     = MEM_NOP;
      ex_wd        = '0;
      ex_wreg      = 1'b0;
      ex_wdata     = '0;
      ex_mem_addr  = '0;
      ex_mem_sdata = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_wd"},   {27'd0, mem_wd}, 32'd0);
      check({tag, "_mem_wreg"}, {31'd0, mem_wreg}, 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_stallreq"}, {31'd0, stallreq}, 32'd0);
      check({tag, "_mc_req"},   {31'd0, mc_bus.mc_req}, 32'd0);
      check({tag, "_mc_we"},    {31'd0, mc_bus.mc_we}, 32'd0);
      check({tag, "_mc_addr"},  mc_bus.mc_addr, 32'd0);
      check({tag, "_mc_size"},  {30'd0, mc_bus.mc_size}, 32'd0);
      check({tag, "_mc_wdata"}, mc_bus.mc_wdata, 32'd0);
   endtask

   // Starts right after a clock edge with the stage in IDLE; ends right after
   // the edge leaving DONE with NOP inputs applied.
   task automatic run_mem(input string tag, input logic [3:0] op,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input int unsigned n, input logic [31:0] rdata,
                          input int unsigned hold, input logic e_we,
                          input logic [1:0] e_size, input logic [31:0] e_wdata);
      int unsigned stall_cnt;
      stall_cnt    = 0;
      ex_memop     = op;
      ex_mem_addr  = addr;
      ex_mem_sdata = sdata;
      ex_wd        = wd;
      ex_wreg      = wreg;
      ex_wdata     = wdata;
      @(negedge clk);
      check({tag, "_issue_req"},   {31'd0, mc_bus.mc_req}, 32'd1);
      check({tag, "_issue_stall"}, {31'd0, stallreq}, 32'd1);
      check({tag, "_issue_we"},    {31'd0, mc_bus.mc_we}, {31'd0, e_we});
      check({tag, "_issue_size"},  {30'd0, mc_bus.mc_size}, {30'd0, e_size});
      check({tag, "_issue_addr"},  mc_bus.mc_addr, addr);
      check({tag, "_issue_wdata"}, mc_bus.mc_wdata, sdata);
      check({tag, "_issue_wreg"},  {31'd0, mem_wreg}, 32'd0);
      if (stallreq) stall_cnt++;
      for (int unsigned i = 1; i <= n; i++) begin
         @(posedge clk);
         #1;
         if (i == n) begin
            mc_bus.mc_done  = 1'b1;
            mc_bus.mc_rdata = rdata;
         end
         @(negedge clk);
         check({tag, "_wait_req"},  {31'd0, mc_bus.mc_req}, 32'd1);
         check({tag, "_wait_wreg"}, {31'd0, mem_wreg}, 32'd0);
         check({tag, "_wait_addr"}, mc_bus.mc_addr, addr);
         if (stallreq) stall_cnt++;
      end
      @(posedge clk);
      #1;
      mc_bus.mc_done  = 1'b0;
      mc_bus.mc_rdata = 32'hA5A5_A5A5;
      stall_sign      = (hold != 0) ? 7'b0100000 : 7'b0000000;
      @(negedge clk);
      if (stallreq) stall_cnt++;
      check({tag, "_stall_cycles"}, stall_cnt, n + 1);
      check({tag, "_done_req"},   {31'd0, mc_bus.mc_req}, 32'd0);
      check({tag, "_done_wd"},    {27'd0, mem_wd}, {27'd0, wd});
      check({tag, "_done_wreg"},  {31'd0, mem_wreg}, {31'd0, wreg});
      check({tag, "_done_wdata"}, mem_wdata, e_wdata);
      // Downstream hold: stray mc_done pulses in DONE must not disturb anything.
      for (int unsigned h = 1; h <= hold; h++) begin
         @(posedge clk);
         #1;
         mc_bus.mc_done  = 1'b1;
         mc_bus.mc_rdata = 32'h0BAD_F00D;
         if (h == hold) stall_sign = '0;
         @(negedge clk);
         check({tag, "_hold_req"},   {31'd0, mc_bus.mc_req}, 32'd0);
         check({tag, "_hold_stall"}, {31'd0, stallreq}, 32'd0);
         check({tag, "_hold_wreg"},  {31'd0, mem_wreg}, {31'd0, wreg});
         check({tag, "_hold_wdata"}, mem_wdata, e_wdata);
      end
      @(posedge clk);
      #1;
      mc_bus.mc_done = 1'b0;
      set_nop();
   endtask

   initial begin
      vecs[0]  = '{MEM_NOP, 5'd5,  1'b1, 32'h0000_1234, 32'h55,  32'h66,
                   5'd5,  1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0};
      vecs[1]  = '{MEM_NOP, 5'd31, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   5'd31, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0};
      vecs[2]  = '{MEM_NOP, 5'd0,  1'b1, 32'h0,        32'h0,   32'h0,
                   5'd0,  1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0};
      vecs[3]  = '{MEM_LB,  5'd7,  1'b1, 32'h99,       32'h100, 32'hAAAA,
                   5'd0,  1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h100, 32'hAAAA};
      vecs[4]  = '{MEM_LH,  5'd7,  1'b1, 32'h99,       32'h102, 32'hAAAA,
                   5'd0,  1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2'b01, 32'h102, 32'hAAAA};
      vecs[5]  = '{MEM_LW,  5'd7,  1'b1, 32'h99,       32'h104, 32'hAAAA,
                   5'd0,  1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2'b11, 32'h104, 32'hAAAA};
      vecs[6]  = '{MEM_LBU, 5'd7,  1'b1, 32'h99,       32'h105, 32'hAAAA,
                   5'd0,  1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h105, 32'hAAAA};
      vecs[7]  = '{MEM_LHU, 5'd7,  1'b1, 32'h99,       32'h106, 32'hAAAA,
                   5'd0,  1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2'b01, 32'h106, 32'hAAAA};
      vecs[8]  = '{MEM_SB,  5'd0,  1'b0, 32'h3,        32'h3,   32'hAB,
                   5'd0,  1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'b00, 32'h3, 32'hAB};
      vecs[9]  = '{MEM_SH,  5'd0,  1'b0, 32'h6,        32'h6,   32'hBEEF,
                   5'd0,  1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'b01, 32'h6, 32'hBEEF};
      vecs[10] = '{MEM_SW,  5'd0,  1'b0, 32'h200,      32'h200, 32'hDEAD_BEEF,
                   5'd0,  1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'b11, 32'h200, 32'hDEAD_BEEF};
      vecs[11] = '{MEM_NOP, 5'd10, 1'b1, 32'hCAFE_F00D, 32'h0,  32'h0,
                   5'd10, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0};

      rst             = 1'b1;
      stall_sign      = '0;
      mc_bus.mc_done  = 1'b0;
      mc_bus.mc_rdata = '0;
      set_nop();

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      check("reset_ld_q", dut.ld_q, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single-cycle view of each op in IDLE, then a reset pulse back to IDLE.
      for (int i = 0; i < 12; i++) begin
         ex_memop     = vecs[i].op;
         ex_wd        = vecs[i].wd;
         ex_wreg      = vecs[i].wreg;
         ex_wdata     = vecs[i].wdata;
         ex_mem_addr  = vecs[i].addr;
         ex_mem_sdata = vecs[i].sdata;
         @(negedge clk);
         check($sformatf("vec%0d_stallreq", i), {31'd0, stallreq}, {31'd0, vecs[i].e_stall});
         check($sformatf("vec%0d_mc_req", i),   {31'd0, mc_bus.mc_req}, {31'd0, vecs[i].e_req});
         check($sformatf("vec%0d_mc_we", i),    {31'd0, mc_bus.mc_we}, {31'd0, vecs[i].e_we});
         check($sformatf("vec%0d_mc_size", i),  {30'd0, mc_bus.mc_size}, {30'd0, vecs[i].e_size});
         check($sformatf("vec%0d_mc_addr", i),  mc_bus.mc_addr, vecs[i].e_addr);
         check($sformatf("vec%0d_mc_wdata", i), mc_bus.mc_wdata, vecs[i].e_mcw);
         check($sformatf("vec%0d_mem_wreg", i), {31'd0, mem_wreg}, {31'd0, vecs[i].e_wreg});
         if (!vecs[i].e_stall) begin
            check($sformatf("vec%0d_mem_wd", i),    {27'd0, mem_wd}, {27'd0, vecs[i].e_wd});
            check($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
         end
         rst = 1'b1;
         set_nop();
         @(posedge clk);
         #1;
         rst = 1'b0;
      end

      // Full accesses, back to back.
      run_mem("lb_lat3", MEM_LB, 32'h100, 32'h0, 5'd7, 1'b1, 32'h99,
              3, 32'h0000_00F0, 0, 1'b0, 2'b00, 32'hFFFF_FFF0);
      run_mem("lhu", MEM_LHU, 32'h110, 32'h0, 5'd8, 1'b1, 32'h0,
              2, 32'h0000_8001, 0, 1'b0, 2'b01, 32'h0000_8001);
      run_mem("lh", MEM_LH, 32'h110, 32'h0, 5'd9, 1'b1, 32'h0,
              1, 32'h0000_8001, 0, 1'b0, 2'b01, 32'hFFFF_8001);
      run_mem("sw", MEM_SW, 32'h200, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h200,
              1, 32'h5555_5555, 0, 1'b1, 2'b11, 32'h200);
      run_mem("lw_hold", MEM_LW, 32'h300, 32'h0, 5'd3, 1'b1, 32'h0,
              2, 32'h1234_5678, 2, 1'b0, 2'b11, 32'h1234_5678);
      run_mem("lbu", MEM_LBU, 32'h301, 32'h0, 5'd4, 1'b1, 32'h0,
              1, 32'hFFFF_FF80, 0, 1'b0, 2'b00, 32'h0000_0080);

      // Back in IDLE: plain passthrough again.
      ex_wd    = 5'd4;
      ex_wreg  = 1'b1;
      ex_wdata = 32'h42;
      @(negedge clk);
      check("post_idle_req",   {31'd0, mc_bus.mc_req}, 32'd0);
      check("post_idle_stall", {31'd0, stallreq}, 32'd0);
      check("post_idle_wd",    {27'd0, mem_wd}, 32'd4);
      check("post_idle_wdata", mem_wdata, 32'h42);

      // Reset in the middle of WAIT, then a late mc_done.
      @(posedge clk);
      #1;
      ex_memop    = MEM_LW;
      ex_mem_addr = 32'h400;
      ex_wd       = 5'd2;
      ex_wreg     = 1'b1;
      @(negedge clk);
      check("rstw_issue_req", {31'd0, mc_bus.mc_req}, 32'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rstw_wait_req", {31'd0, mc_bus.mc_req}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_nop();
      @(negedge clk);
      check_reset_outputs("rstw");
      check("rstw_ld_q", dut.ld_q, 32'd0);
      @(posedge clk);
      #1;
      mc_bus.mc_done  = 1'b1;
      mc_bus.mc_rdata = 32'h1234_5678;
      @(negedge clk);
      check("late_done_req",   {31'd0, mc_bus.mc_req}, 32'd0);
      check("late_done_stall", {31'd0, stallreq}, 32'd0);
      @(posedge clk);
      #1;
      mc_bus.mc_done = 1'b0;
      @(negedge clk);
      check("late_done_ld_q",  dut.ld_q, 32'd0);
      check("late_done_req2",  {31'd0, mc_bus.mc_req}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM pipeline stage of the 5-stage CPU. It sits between the ex_mem register and the mem_wb register.
- Non-memory instructions pass their writeback triple through combinationally.
- Loads and stores run a req/done handshake with the memory controller. The block holds the pipeline via stallreq until the access completes.
- It then presents the load-extended result to mem_wb for exactly one advancing cycle.

Parameters:
- None. Op and size encodings are constants in defines.v.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall_sign  in  7  pipeline stall vector from ctrl; bit 5 set = mem_wb held
- ex_wd  in  5  destination register address
- ex_wreg  in  1  register write enable
- ex_wdata  in  32  ALU result
- ex_memop  in  4  memory op: NOP, LB, LH, LW, LBU, LHU, SB, SH, SW
- ex_mem_addr  in  32  effective address
- ex_mem_sdata  in  32  store data
- mem_wd  out  5  to mem_wb
- mem_wreg  out  1  to mem_wb
- mem_wdata  out  32  to mem_wb
- stallreq  out  1  stall request to ctrl
- mc_req  out  1  memory request, level
- mc_we  out  1  1 = store
- mc_addr  out  32  access address
- mc_size  out  2  00 = byte, 01 = half, 11 = word
- mc_wdata  out  32  store data, low-aligned
- mc_done  in  1  one-cycle completion pulse
- mc_rdata  in  32  load data, low-aligned, valid with mc_done

Behaviour:
- States: IDLE, WAIT, DONE. Reset state is IDLE. The load latch ld_q resets to 0.
- Reset values of outputs in IDLE with NOP input:
  - mem_wd = NOPRegAddr, mem_wreg = WriteDisable, mem_wdata = ZeroWord
  - stallreq = 0, mc_req = 0, mc_we = 0, mc_addr = 0, mc_size = 0, mc_wdata = 0
- IDLE, ex_memop == NOP:
  - Outputs are the combinational copy of ex_wd/ex_wreg/ex_wdata.
  - stallreq = 0, mc_req = 0.
- IDLE, ex_memop != NOP:
  - mc_req = 1 and stallreq = 1 in the same cycle.
  - mc_we = (op is SB/SH/SW). mc_size comes from the op. mc_addr = ex_mem_addr. mc_wdata = ex_mem_sdata.
  - mem_wreg = 0 while stalled.
  - Next state is WAIT.
- WAIT:
  - mc_req and the mc_* fields stay held (driven from the unchanged ex_* inputs).
  - stallreq = 1, mem_wreg = 0.
  - On mc_done, ld_q is captured from mc_rdata:
    - LB: sign-extend [7:0]
    - LBU: zero-extend [7:0]
    - LH: sign-extend [15:0]
    - LHU: zero-extend [15:0]
    - LW: unchanged
  - Next state on mc_done is DONE.
- Memory contract: mc_done never arrives in the same cycle as the first mc_req. Minimum access latency is 1 cycle after issue.
- DONE:
  - mc_req = 0, stallreq = 0.
  - mem_wd = ex_wd, mem_wreg = ex_wreg.
  - mem_wdata = ld_q for loads, ex_wdata for stores (stores have ex_wreg = 0).
  - If stall_sign[5] = 1, stay in DONE with outputs held. Otherwise go to IDLE, since mem_wb captures at this edge.
  - No re-issue from DONE, even though the ex_* inputs still show the same instruction.
- Latency:
  - Non-memory ops: 0 extra cycles.
  - Memory ops: 1 issue cycle + N wait cycles + 1 DONE cycle. stallreq is high for 1 + N cycles.
- Alignment:
  - No misalignment check. The address is passed through as-is.
  - The controller handles byte lanes. Halfword and word accesses are assumed aligned by software.
- Back-to-back memory ops: the next op is seen in IDLE the cycle after DONE and is issued immediately.
- Reset mid-access (WAIT or DONE):
  - State goes to IDLE at the edge.
  - mc_req drops the following cycle. The in-flight transaction is abandoned.
  - mc_done arriving in IDLE is ignored.
- mc_done in IDLE or DONE: ignored.

Decomposition:
- defines.v gains MemOpBus (3:0) and the MemOp constants MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW.
- defines.v also gains the size codes SIZE_B / SIZE_H / SIZE_W.
- The existing NOPRegAddr, WriteDisable, ZeroWord and StallBus constants are reused.
- One sub-module, load_ext: purely combinational. Takes op + 32-bit raw and returns the extended 32-bit value.

Test Plan:
- ALU op passthrough: ex_wd = 5, ex_wreg = 1, ex_wdata = 0x1234, memop = NOP -> same cycle mem_wd = 5, mem_wreg = 1, mem_wdata = 0x1234, stallreq = 0, mc_req = 0.
- LB with sign extension, latency 3: ex_mem_addr = 0x100, memop = LB, wd = 7, mc_done after 3 cycles with rdata = 0x000000F0 ->
  - stallreq high for 4 cycles, mc_size = 00, mc_we = 0
  - DONE cycle: mem_wd = 7, mem_wreg = 1, mem_wdata = 0xFFFFFFF0
- LHU vs LH: rdata = 0x00008001 -> LHU gives 0x00008001, LH gives 0xFFFF8001.
- SW: addr = 0x200, sdata = 0xDEADBEEF, mc_done after 1 cycle ->
  - issue cycle: mc_we = 1, mc_size = 11, mc_wdata = 0xDEADBEEF
  - DONE cycle: mem_wreg = 0, stallreq = 0, no second mc_req
- DONE held by downstream stall: stall_sign[5] = 1 for 2 cycles in DONE -> outputs stable 3 cycles, mc_req stays 0, then IDLE.
- Reset mid-WAIT: assert rst during WAIT ->
  - next cycle: state IDLE, mc_req = 0, stallreq = 0, all outputs at reset values
  - a late mc_done is ignored (ld_q unchanged = 0)
